// File: rtl/dec_reg_bank_pkg.sv
// dec_reg_bank_pkg
// Shared types and constants for the two-entry decoded register bank.
//   state_e       : write FSM state (IDLE accepts writes, COMMIT drains the stage)
//   DEFAULT_WIDTH : default data width of each register
//   sel_is_single : true when exactly one of the two decoded selects is high
package dec_reg_bank_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  function automatic logic sel_is_single(input logic [1:0] sel);
    return ^sel;
  endfunction

endpackage

// File: rtl/dec_reg_cell.sv
// dec_reg_cell
// One WIDTH-bit storage register with asynchronous active-low clear and a
// synchronous load enable.
//   clk   : rising-edge clock
//   rst_n : asynchronous clear, active low
//   load  : when high, d is captured at the next rising edge
//   d     : load data
//   q     : stored value
module dec_reg_cell
  import dec_reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/dec_reg_bank.sv
// dec_reg_bank
// Two-register bank written through a pair of decoded select lines. An
// accepted write with exactly one select high is staged and committed on the
// following edge; both selects high raises a sticky Conflict flag instead,
// and no select high simply consumes the write.
//   Clock         : rising-edge clock
//   nReset        : asynchronous reset, active low
//   Sel0 / Sel1   : decoded write selects for register 0 / register 1
//   WrData        : write data
//   WrValid       : write request
//   WrReady       : high when a write can be accepted (IDLE only)
//   RdSel         : read register index
//   RdData        : registered read data, one-cycle latency
//   Conflict      : sticky flag, set on an accepted write with both selects
//   ClearConflict : synchronous clear of Conflict (a same-edge set wins)
// Build option: define DEC_REG_BANK_BYPASS_EN to forward staged data to
// RdData on the commit edge when the staged target matches RdSel.
module dec_reg_bank
  import dec_reg_bank_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic             Sel0,
  input  logic             Sel1,
  input  logic [WIDTH-1:0] WrData,
  input  logic             WrValid,
  output logic             WrReady,
  input  logic             RdSel,
  output logic [WIDTH-1:0] RdData,
  output logic             Conflict,
  input  logic             ClearConflict
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] stage_data_q;
  logic [WIDTH-1:0] stage_data_d;
  logic [1:0]       stage_sel_q;
  logic [1:0]       stage_sel_d;
  logic             conflict_q;
  logic             conflict_d;
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  logic [1:0]       wr_sel;
  logic             wr_accept;
  logic             wr_ready;
  logic [1:0]       cell_load;
  logic [WIDTH-1:0] cell_q [2];

  assign wr_sel    = {Sel1, Sel0};
  assign wr_accept = WrValid & wr_ready;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Only a single-select write needs the COMMIT cycle;
  // empty and conflicting writes are consumed in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (wr_accept && sel_is_single(wr_sel)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    wr_ready  = 1'b0;
    cell_load = 2'b00;
    case (state_q)
      IDLE: begin
        wr_ready = 1'b1;
      end
      COMMIT: begin
        cell_load = stage_sel_q;
      end
      default: begin
        wr_ready = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Staging register and conflict flag
  // ---------------------------------------------------------------------
  always_comb begin
    stage_data_d = stage_data_q;
    stage_sel_d  = stage_sel_q;
    if (wr_accept && sel_is_single(wr_sel)) begin
      stage_data_d = WrData;
      stage_sel_d  = wr_sel;
    end
  end

  // Set has priority so a conflict arriving alongside a clear is not lost.
  always_comb begin
    conflict_d = conflict_q;
    if (wr_accept && (&wr_sel)) begin
      conflict_d = 1'b1;
    end else if (ClearConflict) begin
      conflict_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data_d = cell_q[RdSel];
`ifdef DEC_REG_BANK_BYPASS_EN
    if ((state_q == COMMIT) && stage_sel_q[RdSel]) begin
      rd_data_d = stage_data_q;
    end
`else
    // Without forwarding, the commit-edge read returns the old contents;
    // the new value becomes visible one edge later.
`endif
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      stage_data_q <= '0;
      stage_sel_q  <= 2'b00;
      conflict_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      stage_data_q <= stage_data_d;
      stage_sel_q  <= stage_sel_d;
      conflict_q   <= conflict_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // ---------------------------------------------------------------------
  // Storage cells
  // ---------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cell
      dec_reg_cell #(
        .WIDTH (WIDTH)
      ) u_cell (
        .clk   (Clock),
        .rst_n (nReset),
        .load  (cell_load[gi]),
        .d     (stage_data_q),
        .q     (cell_q[gi])
      );
    end
  endgenerate

  assign WrReady  = wr_ready;
  assign RdData   = rd_data_q;
  assign Conflict = conflict_q;

endmodule

// File: tb/tb_dec_reg_bank.sv
// tb_dec_reg_bank
// Self-checking bench for dec_reg_bank: a directed vector table, hand-written
// multi-cycle sequences (back-to-back writes, reset during commit) and a
// randomized phase, all cross-checked against a transaction-level model.
module tb_dec_reg_bank;

  localparam int W = 8;
`ifdef DEC_REG_BANK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         nReset = 1'b0;
  logic         Sel0 = 1'b0;
  logic         Sel1 = 1'b0;
  logic [W-1:0] WrData = '0;
  logic         WrValid = 1'b0;
  logic         WrReady;
  logic         RdSel = 1'b0;
  logic [W-1:0] RdData;
  logic         Conflict;
  logic         ClearConflict = 1'b0;

  dec_reg_bank #(.WIDTH(W)) dut (
    .Clock         (Clock),
    .nReset        (nReset),
    .Sel0          (Sel0),
    .Sel1          (Sel1),
    .WrData        (WrData),
    .WrValid       (WrValid),
    .WrReady       (WrReady),
    .RdSel         (RdSel),
    .RdData        (RdData),
    .Conflict      (Conflict),
    .ClearConflict (ClearConflict)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Transaction-level model: register contents, at most one pending write
  // that lands on the edge after it was accepted, and the sticky flag.
  logic [W-1:0] m_reg [2];
  bit           m_conf;
  bit           m_pend;
  int           m_idx;
  logic [W-1:0] m_pdata;
  logic [W-1:0] m_rd;

  typedef struct {
    logic         v, s0, s1, clr, rs;
    logic [W-1:0] d;
    logic [W-1:0] er;
    logic         ey, ec;
  } vec_t;

  vec_t tbl [17];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reg[0] = '0;
    m_reg[1] = '0;
    m_conf   = 1'b0;
    m_pend   = 1'b0;
    m_idx    = 0;
    m_pdata  = '0;
    m_rd     = '0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit accept;
    int rs;
    rs     = int'(RdSel);
    accept = WrValid && !m_pend;
    if (BYP && m_pend && (m_idx == rs)) m_rd = m_pdata;
    else                                m_rd = m_reg[rs];
    if (m_pend) begin
      m_reg[m_idx] = m_pdata;
      m_pend       = 1'b0;
    end
    if (accept && (Sel0 != Sel1)) begin
      m_pend  = 1'b1;
      m_idx   = Sel1 ? 1 : 0;
      m_pdata = WrData;
    end
    if (accept && Sel0 && Sel1) m_conf = 1'b1;
    else if (ClearConflict)     m_conf = 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge Clock);
    #1;
    check("model_rd", RdData, m_rd);
    check("model_ready", {7'd0, WrReady}, {7'd0, !m_pend});
    check("model_conflict", {7'd0, Conflict}, {7'd0, m_conf});
  endtask

  task automatic drive(input logic v, input logic s0, input logic s1,
                       input logic [W-1:0] d, input logic rs, input logic clr);
    WrValid       = v;
    Sel0          = s0;
    Sel1          = s1;
    WrData        = d;
    RdSel         = rs;
    ClearConflict = clr;
  endtask

  function automatic vec_t mk(input logic v, input logic s0, input logic s1,
                              input logic [W-1:0] d, input logic rs, input logic clr,
                              input logic [W-1:0] er, input logic ey, input logic ec);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.d = d; r.rs = rs; r.clr = clr;
    r.er = er; r.ey = ey; r.ec = ec;
    return r;
  endfunction

  initial begin
    int acc_edge [$];
    int cyc;
    bit rdy;
    logic [W-1:0] seq_d [3];
    logic         seq_s1 [3];

    // ---------------- reset ----------------
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check("reset_rd", RdData, 8'h00);
    check("reset_ready", {7'd0, WrReady}, 8'h01);
    check("reset_conflict", {7'd0, Conflict}, 8'h00);
    @(negedge Clock);
    nReset = 1'b1;

    // ---------------- directed table ----------------
    tbl[0]  = mk(1, 1, 0, 8'h5A, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(0, 0, 0, 8'h00, 0, 0, BYP ? 8'h5A : 8'h00, 1, 0);
    tbl[2]  = mk(0, 0, 0, 8'h00, 0, 0, 8'h5A, 1, 0);
    tbl[3]  = mk(1, 1, 1, 8'hFF, 0, 0, 8'h5A, 1, 1);
    tbl[4]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 1);
    tbl[5]  = mk(0, 0, 0, 8'h00, 0, 1, 8'h5A, 1, 0);
    tbl[6]  = mk(1, 0, 0, 8'h77, 0, 0, 8'h5A, 1, 0);
    tbl[7]  = mk(0, 0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    tbl[8]  = mk(1, 0, 1, 8'h3C, 1, 0, 8'h00, 0, 0);
    tbl[9]  = mk(0, 0, 0, 8'h00, 1, 0, BYP ? 8'h3C : 8'h00, 1, 0);
    tbl[10] = mk(0, 0, 0, 8'h00, 1, 0, 8'h3C, 1, 0);
    tbl[11] = mk(1, 1, 1, 8'hEE, 1, 1, 8'h3C, 1, 1);
    tbl[12] = mk(0, 0, 0, 8'h00, 0, 1, 8'h5A, 1, 0);
    tbl[13] = mk(1, 1, 0, 8'h11, 0, 0, 8'h5A, 0, 0);
    tbl[14] = mk(1, 0, 1, 8'h99, 1, 0, 8'h3C, 1, 0);
    tbl[15] = mk(0, 0, 0, 8'h00, 0, 0, 8'h11, 1, 0);
    tbl[16] = mk(0, 0, 0, 8'h00, 1, 0, 8'h3C, 1, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].v, tbl[i].s0, tbl[i].s1, tbl[i].d, tbl[i].rs, tbl[i].clr);
      step();
      check("vec_rd", RdData, tbl[i].er);
      check("vec_ready", {7'd0, WrReady}, {7'd0, tbl[i].ey});
      check("vec_conflict", {7'd0, Conflict}, {7'd0, tbl[i].ec});
      $display("vec %0d: v=%0b sel=%0b%0b d=%02h rs=%0b clr=%0b -> rd=%02h ready=%0b conflict=%0b",
               i, tbl[i].v, tbl[i].s1, tbl[i].s0, tbl[i].d, tbl[i].rs, tbl[i].clr,
               RdData, WrReady, Conflict);
    end

    // ---------------- continuous writes: reg1, reg0, reg1 ----------------
    seq_d[0] = 8'h11; seq_s1[0] = 1'b1;
    seq_d[1] = 8'h22; seq_s1[1] = 1'b0;
    seq_d[2] = 8'h33; seq_s1[2] = 1'b1;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, !seq_s1[i], seq_s1[i], seq_d[i], 1'b0, 1'b0);
      rdy = 1'b0;
      for (int t = 0; t < 4; t++) begin
        rdy = WrReady;
        step();
        cyc++;
        if (rdy) begin
          acc_edge.push_back(cyc);
          break;
        end
      end
      check("burst_accept_timeout", {7'd0, rdy}, 8'h01);
      $display("burst write %0d: data=%02h reg%0d accepted at edge %0d", i, seq_d[i],
               seq_s1[i] ? 1 : 0, cyc);
    end
    if (acc_edge.size() == 3) begin
      check("burst_spacing_a", 8'(acc_edge[1] - acc_edge[0]), 8'd2);
      check("burst_spacing_b", 8'(acc_edge[2] - acc_edge[1]), 8'd2);
    end
    drive(0, 0, 0, 8'h00, 0, 0);
    step();
    step();
    check("burst_reg0", RdData, 8'h22);
    drive(0, 0, 0, 8'h00, 1, 0);
    step();
    check("burst_reg1", RdData, 8'h33);
    $display("burst readback: reg1=%02h", RdData);

    // ---------------- reset during commit ----------------
    drive(1, 1, 1, 8'hFF, 1, 0);
    step();
    check("pre_reset_conflict", {7'd0, Conflict}, 8'h01);
    drive(1, 0, 1, 8'hA5, 1, 0);
    step();
    check("pre_reset_ready", {7'd0, WrReady}, 8'h00);
    drive(0, 0, 0, 8'h00, 1, 0);
    #2;
    nReset = 1'b0;
    #1;
    model_reset();
    check("abort_rd", RdData, 8'h00);
    check("abort_ready", {7'd0, WrReady}, 8'h01);
    check("abort_conflict", {7'd0, Conflict}, 8'h00);
    @(negedge Clock);
    nReset = 1'b1;
    step();
    step();
    check("abort_reg1", RdData, 8'h00);
    drive(0, 0, 0, 8'h00, 0, 0);
    step();
    check("abort_reg0", RdData, 8'h00);
    $display("reset during commit: reg1=00 reg0=%02h conflict=%0b", RdData, Conflict);

    // ---------------- randomized phase ----------------
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), 1'(($urandom)), 1'(($urandom)),
            W'($urandom), 1'(($urandom)), ($urandom_range(0, 7) == 0));
      step();
    end
    $display("random phase: 400 cycles against model");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
